// File: rtl/avg_pkg.sv
// avg_pkg -- shared definitions for the window-average decoder.
//   SCALE, WINDOW   : per-sample scale and samples per window
//   *_DEF           : default widths and divisor for avg_decoder
//   avg_state_e     : decoder FSM state encoding
package avg_pkg;

  localparam int unsigned SCALE       = 25;
  localparam int unsigned WINDOW      = 4;
  localparam int unsigned DIVISOR_DEF = SCALE * WINDOW;
  localparam int unsigned IN_W_DEF    = 13;
  localparam int unsigned Q_W_DEF     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } avg_state_e;

endpackage

// File: rtl/div_step.sv
// div_step -- one combinational restoring-division step.
//   rem_sh  [W:0]   : partial remainder shifted left with the next dividend bit
//   divisor [W:0]   : divisor, zero-extended
//   rem_new [W-1:0] : partial remainder after the step
//   q_bit           : quotient bit produced by this step
module div_step #(
  parameter int unsigned W = 13
) (
  input  logic [W:0]   rem_sh,
  input  logic [W:0]   divisor,
  output logic [W-1:0] rem_new,
  output logic         q_bit
);

  always_comb begin
    q_bit   = (rem_sh >= divisor);
    // Result is below divisor in both branches, so it always fits in W bits.
    rem_new = W'(q_bit ? (rem_sh - divisor) : rem_sh);
  end

endmodule

// File: rtl/avg_decoder.sv
// avg_decoder -- recovers the average sample from an accumulated window sum
// by sequential restoring division (one quotient bit per clock, MSB first).
//
// Ports:
//   clock, reset       : rising-edge clock, asynchronous active-low reset
//   in_sum/in_valid    : window sum to decode; in_ready high while IDLE
//   out_x              : in_sum / DIVISOR, clamped to 2^Q_W-1 (out_sat flags it)
//   out_rem            : true remainder in_sum % DIVISOR
//   out_valid/out_ready: result handshake; result held until accepted
//
// Configuration macro:
//   AVG_DECODER_ROUND_EN : round the quotient to nearest (half up) before the
//                          saturation check; costs one extra cycle of latency.
module avg_decoder
  import avg_pkg::*;
#(
  parameter int unsigned IN_W    = IN_W_DEF,
  parameter int unsigned DIVISOR = DIVISOR_DEF,
  parameter int unsigned Q_W     = Q_W_DEF
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [IN_W-1:0] in_sum,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [Q_W-1:0]  out_x,
  output logic [IN_W-1:0] out_rem,
  output logic            out_sat,
  output logic            out_valid,
  input  logic            out_ready
);

  localparam int unsigned CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam logic [IN_W:0]   DIV_C = (IN_W+1)'(DIVISOR);
  localparam logic [IN_W-1:0] Q_MAX = IN_W'((2 ** Q_W) - 1);

  avg_state_e state, state_nx;

  logic [1:0]       rst_sync;
  logic             rst_ok;
  logic             accept;

  logic [IN_W-1:0]  dvd;
  logic [IN_W-1:0]  quo;
  logic [IN_W-1:0]  rem;
  logic [CNT_W-1:0] cnt;
  logic             fin;
`ifdef AVG_DECODER_ROUND_EN
  logic             rnd_done;
`endif

  logic [IN_W:0]    step_rem_sh;
  logic [IN_W-1:0]  step_rem;
  logic             step_q;

  // Reset release is synchronised; accepts are blocked until it propagates.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_ok = rst_sync[1];
  assign accept = (state == IDLE) && in_valid && rst_ok;

  // in_ready reads 1 while reset is held, drops during the release
  // synchroniser window so no handshake is offered that would be refused.
  assign in_ready  = (state == IDLE) && (rst_ok || !reset);
  assign out_valid = (state == DONE) && fin;

  assign step_rem_sh = {rem, dvd[IN_W-1]};

  div_step #(
    .W (IN_W)
  ) u_step (
    .rem_sh  (step_rem_sh),
    .divisor (DIV_C),
    .rem_new (step_rem),
    .q_bit   (step_q)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept)                 state_nx = DIV;
      DIV:     if (cnt == '0)              state_nx = DONE;
      DONE:    if (out_valid && out_ready) state_nx = IDLE;
      default:                             state_nx = IDLE;
    endcase
  end

  // DONE spends its first cycle (two with rounding) finalising the result
  // into the output registers; fin marks the result as presented.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dvd      <= '0;
      quo      <= '0;
      rem      <= '0;
      cnt      <= '0;
      fin      <= 1'b0;
      out_x    <= '0;
      out_rem  <= '0;
      out_sat  <= 1'b0;
`ifdef AVG_DECODER_ROUND_EN
      rnd_done <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            dvd      <= in_sum;
            quo      <= '0;
            rem      <= '0;
            cnt      <= CNT_W'(IN_W - 1);
            fin      <= 1'b0;
`ifdef AVG_DECODER_ROUND_EN
            rnd_done <= 1'b0;
`endif
          end
        end
        DIV: begin
          dvd <= dvd << 1;
          rem <= step_rem;
          quo <= (quo << 1) | IN_W'(step_q);
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        DONE: begin
`ifdef AVG_DECODER_ROUND_EN
          if (!rnd_done) begin
            rnd_done <= 1'b1;
            if ({rem, 1'b0} >= DIV_C) quo <= quo + 1'b1;
          end else if (!fin) begin
`else
          if (!fin) begin
`endif
            fin     <= 1'b1;
            out_sat <= (quo > Q_MAX);
            out_x   <= (quo > Q_MAX) ? '1 : quo[Q_W-1:0];
            out_rem <= rem;
          end else if (out_ready) begin
            fin <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
